// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg: Wishbone cycle-type codes and slave FSM states shared by the memory slave.
package zap_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BURST} state_t;
endpackage

// File: rtl/zap_wb_ram.sv
// zap_wb_ram: single-port DEPTH x 32 storage, byte-enabled synchronous write, combinational read.
module zap_wb_ram #(
  parameter logic [31:0] DEPTH = 32'd4096,
  parameter int          AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_sel,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdat,
  output logic [31:0]   o_rdat
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge i_clk)
    for (int i = 0; i < 4; i++)
      if (i_we && i_sel[i]) mem_q[i_addr][8*i +: 8] <= i_wdat[8*i +: 8];
  assign o_rdat = mem_q[i_addr];
endmodule

// File: rtl/zap_wb_slave_mem.sv
// zap_wb_slave_mem: Wishbone registered-feedback memory slave with linear incrementing bursts.
// Define ZAP_WB_SLAVE_WAIT_EN to compile in WAIT_CYCLES idle cycles before the first ack.
module zap_wb_slave_mem
  import zap_wb_pkg::*;
#(
  parameter logic [31:0] DEPTH_WORDS = 32'd4096,
  parameter logic [31:0] WAIT_CYCLES = 32'd2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d, rdat;
  logic          req, done, wr;
  logic          unused;
`ifdef ZAP_WB_SLAVE_WAIT_EN
  logic [7:0] wcnt_q, wcnt_d;
  localparam state_t FIRST = (WAIT_CYCLES == 32'd0) ? ST_ACK : ST_WAIT;
`else
  localparam state_t FIRST = ST_ACK;
`endif
  assign unused = ^{i_wb_bte, i_wb_adr[31:AW+2], i_wb_adr[1:0], WAIT_CYCLES};
  assign req  = i_wb_cyc & i_wb_stb;
  assign done = ack_q & req;
  assign wr   = done & i_wb_we;
  // ACK with ack low is the pending ack decision; the cti seen at the ack edge picks ACK or BURST
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
`ifdef ZAP_WB_SLAVE_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = FIRST;
        cnt_d   = i_wb_adr[AW+1:2];
`ifdef ZAP_WB_SLAVE_WAIT_EN
        wcnt_d  = 8'd0;
`endif
      end
`ifdef ZAP_WB_SLAVE_WAIT_EN
      ST_WAIT: if (wcnt_q == WAIT_CYCLES[7:0] - 8'd1) state_d = ST_ACK;
               else wcnt_d = wcnt_q + 8'd1;
`endif
      ST_ACK: if (ack_q) state_d = ST_IDLE;
              else begin
                ack_d   = req;
                state_d = (req && i_wb_cti == CTI_BURST) ? ST_BURST : ST_ACK;
              end
      ST_BURST: begin
        cnt_d   = done ? cnt_q + 1'b1 : cnt_q;
        ack_d   = i_wb_stb & ~(done & (i_wb_cti == CTI_EOB));
        state_d = (done && i_wb_cti == CTI_EOB) ? ST_IDLE : ST_BURST;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_wb_cyc) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
    end
    dat_d = ack_d ? rdat : 32'd0;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
`ifdef ZAP_WB_SLAVE_WAIT_EN
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) wcnt_q <= 8'd0;
    else wcnt_q <= wcnt_d;
`endif
  // one address port: the committing beat's word on writes, the next word to present otherwise
  zap_wb_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .i_clk  (i_clk),
    .i_we   (wr),
    .i_sel  (i_wb_sel),
    .i_addr (wr ? cnt_q : cnt_d),
    .i_wdat (i_wb_dat),
    .o_rdat (rdat)
  );
  assign o_wb_ack = ack_q;
  assign o_wb_dat = dat_q;
endmodule
